switch_debouncer: RTL and testbench

Debounces one raw mechanical switch or push-button input and produces a clean, glitch-free level. It sits directly upstream of `rising_edge_detector` and drives that block's `level` input. The raw input is resynchronised into `clk`. A change is accepted only after the input has held its new value for `SAMPLES` consecutive sample ticks; each sample tick is 2^N clock cycles apart.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 20 ++
 rtl/switch_debouncer.sv | 107 ++++++++++
 tb/tb_switch_debouncer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer.
// State encoding reuses the edge detector's 2-bit width.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  function automatic int q_width(input int samples);
    int w;
    w = $clog2(samples);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-tick generator.
// One-cycle m_tick every 2^N clocks.
module sample_tick_gen #(
  parameter int N = 19
) (
  input  logic clk,
  input  logic reset,
  output logic m_tick
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + N'(1);
  end

  assign m_tick = &cnt;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch into a clean level.
// A change must hold for SAMPLES sample ticks.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int N       = 19,
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic pending
);

  localparam int QW = q_width(SAMPLES);
  localparam logic [QW-1:0] Q_LOAD =
    QW'(SAMPLES - 1);

  logic          s1;
  logic          sw_s;
  logic          m_tick;
  logic [QW-1:0] q;
  logic [QW-1:0] q_next;
  state_t        state_reg;
  state_t        state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      sw_s <= 1'b0;
    end else begin
      s1   <= sw;
      sw_s <= s1;
    end
  end

  sample_tick_gen #(
    .N(N)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .m_tick (m_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ZERO;
      q         <= '0;
    end else begin
      state_reg <= state_next;
      q         <= q_next;
    end
  end

  // Abort (input back at old level) wins over m_tick.
  always_comb begin
    state_next = state_reg;
    q_next     = q;
    unique case (state_reg)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          q_next     = Q_LOAD;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
        end else if (m_tick) begin
          if (q == '0) state_next = ONE;
          else         q_next     = q - 1'b1;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          q_next     = Q_LOAD;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
        end else if (m_tick) begin
          if (q == '0) state_next = ZERO;
          else         q_next     = q - 1'b1;
        end
      end
      default: state_next = ZERO;
    endcase
  end

  always_comb begin
    db_level = 1'b0;
    pending  = 1'b0;
    unique case (1'b1)
      (state_reg == WAIT1): pending  = 1'b1;
      (state_reg == ONE):   db_level = 1'b1;
      (state_reg == WAIT0): begin
        db_level = 1'b1;
        pending  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: SAMPLES=3 and SAMPLES=1 instances
// checked against a run-length qualification model.
module tb_switch_debouncer;

  localparam int N = 3;
  localparam int P = 8;

  int   samp [2] = '{3, 1};
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sw    = 1'b0;
  logic [1:0] db;
  logic [1:0] pd;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(.N(N), .SAMPLES(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db[0]),
    .pending  (pd[0])
  );

  switch_debouncer #(.N(N), .SAMPLES(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db[1]),
    .pending  (pd[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    bit val;
    int cyc;
  } ev_t;

  ev_t sbq0[$];
  ev_t sbq1[$];

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: sw seen through a 2-cycle delay line; a level
  // differing from the accepted one opens a candidate run,
  // which is dropped when the level returns and accepted
  // once SAMPLES tick edges have been seen inside it.
  bit dl [2];
  bit m_db [2];
  bit m_pd [2];
  int m_seen [2];
  int cyc = 0;

  always @(posedge clk) begin
    if (reset) begin
      dl = '{0, 0};
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        m_db[k] = 0;
        m_pd[k] = 0;
        m_seen[k] = 0;
      end
      sbq0.delete();
      sbq1.delete();
    end else begin
      bit tick;
      bit lvl;
      ev_t e;
      tick = ((cyc % P) == P - 1);
      lvl = dl[1];
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!m_pd[k]) begin
          if (lvl != m_db[k]) begin
            m_pd[k] = 1;
            m_seen[k] = 0;
          end
        end else if (lvl == m_db[k]) begin
          m_pd[k] = 0;
        end else if (tick) begin
          m_seen[k]++;
          if (m_seen[k] == samp[k]) begin
            m_db[k] = lvl;
            m_pd[k] = 0;
            e.val = lvl;
            e.cyc = cyc;
            if (k == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
          end
        end
      end
      dl[1] = dl[0];
      dl[0] = sw;
    end
  end

  bit prev [2] = '{0, 0};
  int rise_at [2] = '{-1, -1};

  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        check(db[k] === 1'b0, "reset_db", db[k], 0);
        check(pd[k] === 1'b0, "reset_pend", pd[k], 0);
        prev[k] = 0;
        rise_at[k] = -1;
      end else begin
        check(pd[k] === m_pd[k], "pending",
              pd[k], m_pd[k]);
        if (db[k] !== prev[k]) begin
          ev_t e;
          bit got;
          got = 0;
          if (k == 0 && sbq0.size() > 0) begin
            e = sbq0.pop_front();
            got = 1;
          end
          if (k == 1 && sbq1.size() > 0) begin
            e = sbq1.pop_front();
            got = 1;
          end
          check(got, "unexpected_edge", db[k], prev[k]);
          if (got) begin
            check(db[k] === e.val, "edge_val", db[k], e.val);
            check(cyc == e.cyc, "edge_cyc", cyc, e.cyc);
          end
          if (db[k] === 1'b1) rise_at[k] = cyc;
          prev[k] = db[k];
        end
      end
    end
  end

  task automatic wait_db(input int k, input bit v,
                         input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (db[k] === v) begin
        at = cyc;
        break;
      end
    end
    check(at >= 0, "wait_timeout", at, budget);
  endtask

  task automatic do_reset(input bit swv);
    @(negedge clk);
    sw = swv;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int at;
    int t0;
    bit saw;
    bit ok;

    sw = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_db(0, 1'b1, 40, at);
    check(at >= 19 && at <= 27, "press_rise", at, 23);
    repeat (10) @(negedge clk);
    check(db[0] === 1'b1, "press_hold", db[0], 1);
    check(rise_at[1] >= 1 && rise_at[1] <= 11,
          "s1_rise", rise_at[1], 11);

    do_reset(1'b0);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      sw = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (pd[0]) saw = 1;
      if (db[0]) saw = 0;
    end
    sw = 1'b0;
    repeat (30) @(negedge clk);
    check(db[0] === 1'b0, "bounce_db", db[0], 0);
    check(saw, "bounce_pending", saw, 1);
    check(pd[0] === 1'b0, "bounce_idle", pd[0], 0);

    @(negedge clk);
    sw = 1'b1;
    wait_db(0, 1'b1, 40, at);
    @(negedge clk);
    sw = 1'b0;
    repeat (5) @(negedge clk);
    sw = 1'b1;
    repeat (2) @(negedge clk);
    sw = 1'b0;
    t0 = cyc;
    wait_db(0, 1'b0, 60, at);
    check(at - t0 >= 19 && at - t0 <= 27,
          "release_fall", at - t0, 23);

    do_reset(1'b0);
    @(negedge clk);
    sw = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dut.state_reg == 2'b01 && dut.q == 2'd1) begin
        ok = 1;
        break;
      end
    end
    check(ok, "reach_wait1_q1", ok, 1);
    check(pd[0] === 1'b1, "midq_pending", pd[0], 1);
    reset = 1'b1;
    #1;
    check(db[0] === 1'b0, "midq_db", db[0], 0);
    check(pd[0] === 1'b0, "midq_pend", pd[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_db(0, 1'b1, 40, at);
    check(at >= 19 && at <= 27, "midq_rise", at, 23);

    do_reset(1'b0);
    for (int r = 0; r < 60; r++) begin
      sw = ~sw;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check(sbq0.size() == 0, "sb_empty0", sbq0.size(), 0);
    check(sbq1.size() == 0, "sb_empty1", sbq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
